// File: rtl/axi_lite_cmd_regs.sv
// axi_lite_cmd_regs: AXI4-Lite register bank holding the regex coprocessor command inputs and exposing its status/data outputs.
module axi_lite_cmd_regs #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [REG_WIDTH-1:0]   s_wdata,
  input  logic [REG_WIDTH/8-1:0] s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDR_WIDTH-1:0]  s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [REG_WIDTH-1:0]   s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [REG_WIDTH-1:0]   data_in_register,
  output logic [REG_WIDTH-1:0]   address_register,
  output logic [REG_WIDTH-1:0]   start_cc_pointer_register,
  output logic [REG_WIDTH-1:0]   end_cc_pointer_register,
  output logic [REG_WIDTH-1:0]   cmd_register,
  input  logic [REG_WIDTH-1:0]   status_register,
  input  logic [REG_WIDTH-1:0]   data_o_register
);
  localparam int NB = REG_WIDTH / 8;
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] OFF_RO  = ADDR_WIDTH'('h14);
  localparam logic [ADDR_WIDTH-1:0] OFF_END = ADDR_WIDTH'('h1C);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic aw_done, w_done, aw_hs, w_hs, ar_hs, commit, wr_ok, rd_err;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr, wr_addr;
  logic [REG_WIDTH-1:0] w_data, wr_data, rd_sel;
  logic [NB-1:0] w_strb, wr_strb;
  logic [IW-1:0] wr_idx;
  logic [REG_WIDTH-1:0] regs [5];
  assign data_in_register          = regs[0];
  assign address_register          = regs[1];
  assign start_cc_pointer_register = regs[2];
  assign end_cc_pointer_register   = regs[3];
  assign cmd_register              = regs[4];
  // Write side: the commit uses whichever of AW/W is arriving this edge so a same-cycle pair responds next cycle.
  assign aw_hs   = s_awvalid && s_awready;
  assign w_hs    = s_wvalid && s_wready;
  assign wr_addr = aw_done ? aw_addr : s_awaddr;
  assign wr_data = w_done ? w_data : s_wdata;
  assign wr_strb = w_done ? w_strb : s_wstrb;
  assign wr_idx  = wr_addr[ADDR_WIDTH-1:2];
  assign wr_ok   = wr_addr < OFF_RO;
  assign commit  = w_state == W_IDLE && (aw_done || aw_hs) && (w_done || w_hs);
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      s_bresp <= OKAY;
    end else begin
      w_state <= w_next;
      aw_done <= (w_state == W_RESP && s_bready) ? 1'b0 : aw_done || aw_hs;
      w_done  <= (w_state == W_RESP && s_bready) ? 1'b0 : w_done || w_hs;
      if (commit) s_bresp <= wr_ok ? OKAY : SLVERR;
    end
    if (aw_hs) aw_addr <= s_awaddr;
    if (w_hs) begin
      w_data <= s_wdata;
      w_strb <= s_wstrb;
    end
  end
  always_comb begin
    w_next = w_state;
    if (w_state == W_IDLE && commit) w_next = W_RESP;
    if (w_state == W_RESP && s_bready) w_next = W_IDLE;
  end
  always_comb begin
    s_awready = !rst && w_state == W_IDLE && !aw_done;
    s_wready  = !rst && w_state == W_IDLE && !w_done;
    s_bvalid  = w_state == W_RESP;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst) regs[i] <= '0;
      else if (commit && wr_ok && wr_idx == IW'(i))
        for (int b = 0; b < NB; b++)
          if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end
  // Read side: R_WAIT gives the BRAM behind data_o_register its one cycle of read latency.
  assign ar_hs  = s_arvalid && s_arready;
  assign rd_err = ar_addr >= OFF_END;
  always_comb begin
    rd_sel = '0;
    case (ar_addr[ADDR_WIDTH-1:2])
      IW'(0): rd_sel = regs[0];
      IW'(1): rd_sel = regs[1];
      IW'(2): rd_sel = regs[2];
      IW'(3): rd_sel = regs[3];
      IW'(4): rd_sel = regs[4];
      IW'(5): rd_sel = status_register;
      IW'(6): rd_sel = data_o_register;
      default: rd_sel = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      s_rdata <= '0;
      s_rresp <= OKAY;
    end else begin
      r_state <= r_next;
      if (r_state == R_WAIT) begin
        s_rdata <= rd_err ? '0 : rd_sel;
        s_rresp <= rd_err ? SLVERR : OKAY;
      end
    end
    if (ar_hs) ar_addr <= s_araddr;
  end
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  r_next = ar_hs ? R_WAIT : R_IDLE;
      R_WAIT:  r_next = R_DATA;
      R_DATA:  r_next = s_rready ? R_IDLE : R_DATA;
      default: r_next = R_IDLE;
    endcase
  end
  always_comb begin
    s_arready = !rst && r_state == R_IDLE;
    s_rvalid  = r_state == R_DATA;
  end
endmodule

// File: tb/tb_axi_lite_cmd_regs.sv
// tb_axi_lite_cmd_regs: directed bench for the AXI4-Lite command register bank.
module tb_axi_lite_cmd_regs;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0, status = '0, data_o = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, r_din, r_addr, r_start, r_end, r_cmd;
  int n_cmp = 0, n_err = 0;
  logic [1:0] resp;
  logic [31:0] data;
  axi_lite_cmd_regs #(.REG_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready),
    .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready),
    .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid), .s_rready(rready),
    .data_in_register(r_din), .address_register(r_addr),
    .start_cc_pointer_register(r_start), .end_cc_pointer_register(r_end),
    .cmd_register(r_cmd), .status_register(status), .data_o_register(data_o)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    logic ah, wh;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick();
      if (ah) awvalid = 0;
      if (wh) wvalid = 0;
    end
    for (int i = 0; i < 20 && !bvalid; i++) tick();
    chk("wr_bvalid_timeout", {31'b0, bvalid}, 32'd1);
    r = bresp;
    bready = 1;
    tick();
    bready = 0;
  endtask
  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20 && !arready; i++) tick();
    tick();
    arvalid = 0;
    for (int i = 0; i < 20 && !rvalid; i++) tick();
    chk("rd_rvalid_timeout", {31'b0, rvalid}, 32'd1);
    d = rdata; r = rresp;
    rready = 1;
    tick();
    rready = 0;
  endtask
  initial begin
    #1;
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    tick();
    rst = 0;
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_din", r_din, 32'd0);
    chk("rst_cmd", r_cmd, 32'd0);
    axi_read(6'h10, data, resp);
    chk("rd_cmd_rst_data", data, 32'd0);
    chk("rd_cmd_rst_resp", {30'b0, resp}, 32'd0);
    // AW alone at cycle 0, W at cycle 3, response cycle 4
    awaddr = 6'h04; awvalid = 1;
    chk("t2_awready", {31'b0, awready}, 32'd1);
    tick();
    awvalid = 0;
    tick();
    chk("t2_bvalid_early", {31'b0, bvalid}, 32'd0);
    tick();
    wdata = 32'h0000_01A5; wstrb = 4'hF; wvalid = 1;
    chk("t2_wready", {31'b0, wready}, 32'd1);
    chk("t2_awready_latched", {31'b0, awready}, 32'd0);
    tick();
    wvalid = 0;
    chk("t2_bvalid", {31'b0, bvalid}, 32'd1);
    chk("t2_bresp", {30'b0, bresp}, 32'd0);
    chk("t2_addr_reg", r_addr, 32'h1A5);
    awaddr = 6'h08; awvalid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_awready_hold", {31'b0, awready}, 32'd0);
      tick();
      chk("t2_bvalid_hold", {31'b0, bvalid}, 32'd1);
    end
    awvalid = 0;
    bready = 1;
    tick();
    bready = 0;
    chk("t2_bvalid_clr", {31'b0, bvalid}, 32'd0);
    chk("t2_awready_back", {31'b0, awready}, 32'd1);
    chk("t2_start_untouched", r_start, 32'd0);
    axi_write(6'h00, 32'h1234_5678, 4'hF, resp);
    axi_write(6'h00, 32'hDEAD_BEEF, 4'h3, resp);
    chk("t3_din_strb", r_din, 32'h1234_BEEF);
    chk("t3_bresp", {30'b0, resp}, 32'd0);
    axi_read(6'h00, data, resp);
    chk("t3_rd_din", data, 32'h1234_BEEF);
    axi_write(6'h13, 32'h0000_00AA, 4'h1, resp);
    chk("cmd_byte_lowbits", r_cmd, 32'h0000_00AA);
    status = 32'h0000_0042;
    axi_write(6'h14, 32'hFFFF_FFFF, 4'hF, resp);
    chk("t4_ro_bresp", {30'b0, resp}, 32'd2);
    axi_write(6'h1C, 32'hFFFF_FFFF, 4'hF, resp);
    chk("t4_oor_bresp", {30'b0, resp}, 32'd2);
    chk("t4_din_kept", r_din, 32'h1234_BEEF);
    chk("t4_cmd_kept", r_cmd, 32'h0000_00AA);
    axi_read(6'h14, data, resp);
    chk("t4_status_rd", data, 32'h42);
    axi_read(6'h20, data, resp);
    chk("t4_oor_rdata", data, 32'd0);
    chk("t4_oor_rresp", {30'b0, resp}, 32'd2);
    data_o = 32'hCAFE_0001;
    axi_read(6'h18, data, resp);
    chk("rd_data_o", data, 32'hCAFE_0001);
    chk("rd_data_o_resp", {30'b0, resp}, 32'd0);
    status = 32'h3;
    araddr = 6'h14; arvalid = 1;
    chk("t5_arready", {31'b0, arready}, 32'd1);
    tick();
    arvalid = 0;
    chk("t5_rvalid_c1", {31'b0, rvalid}, 32'd0);
    tick();
    chk("t5_rvalid_c2", {31'b0, rvalid}, 32'd1);
    chk("t5_rdata", rdata, 32'h3);
    for (int i = 0; i < 3; i++) begin
      status = 32'h100 + i;
      tick();
      chk("t5_rdata_hold", rdata, 32'h3);
      chk("t5_rvalid_hold", {31'b0, rvalid}, 32'd1);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("t5_rvalid_clr", {31'b0, rvalid}, 32'd0);
    awaddr = 6'h10; wdata = 32'h7; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 6'h00; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    tick();
    chk("t6_cmd_set", r_cmd, 32'h7);
    chk("t6_bvalid_pre", {31'b0, bvalid}, 32'd1);
    chk("t6_rvalid_pre", {31'b0, rvalid}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_bvalid_rst", {31'b0, bvalid}, 32'd0);
    chk("t6_rvalid_rst", {31'b0, rvalid}, 32'd0);
    chk("t6_cmd_rst", r_cmd, 32'd0);
    chk("t6_addr_rst", r_addr, 32'd0);
    chk("t6_din_rst", r_din, 32'd0);
    axi_write(6'h0C, 32'hA5A5_0F0F, 4'hF, resp);
    chk("t6_end_ptr", r_end, 32'hA5A5_0F0F);
    chk("t6_bresp", {30'b0, resp}, 32'd0);
    axi_read(6'h0C, data, resp);
    chk("t6_rd_end_ptr", data, 32'hA5A5_0F0F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
